// File: rtl/wash_seq_pkg.sv
// wash_seq_pkg: opcodes, state encoding, fault codes and field widths shared by the wash sequencer.
package wash_seq_pkg;
  localparam int OP_W = 8;
  localparam int IDX_W = 8;
  localparam int ARG_W = 16;
  localparam logic [OP_W-1:0] OP_HALT = 8'h00;
  localparam logic [OP_W-1:0] OP_WAIT = 8'h10;
  localparam logic [OP_W-1:0] OP_RUN  = 8'h11;
  localparam logic [OP_W-1:0] OP_SET  = 8'h21;
  localparam logic [OP_W-1:0] OP_DEC  = 8'h22;
  localparam logic [OP_W-1:0] OP_J    = 8'h30;
  localparam logic [OP_W-1:0] OP_JZ   = 8'h31;
  localparam logic [OP_W-1:0] OP_JNZ  = 8'h32;
  localparam logic [OP_W-1:0] OP_CALL = 8'h33;
  localparam logic [OP_W-1:0] OP_RET  = 8'h34;
  typedef enum logic [1:0] {S_EXEC, S_TIMED, S_HALT, S_FAULT} state_e;
  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_IDX     = 3'd2;
  localparam logic [2:0] FC_OVF     = 3'd3;
  localparam logic [2:0] FC_UNF     = 3'd4;
endpackage

// File: rtl/call_stack.sv
// call_stack: return-address LIFO; full at sp==STACK_DEPTH, empty at sp==0.
module call_stack #(
  parameter int ADDR_WIDTH = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  logic [SW-1:0] sp_q, sp_d;
  // Power-of-two storage keeps the sp-indexed accesses width-exact.
  logic [ADDR_WIDTH-1:0] mem_q [1<<SW];
  assign full = sp_q == SW'(STACK_DEPTH);
  assign empty = sp_q == '0;
  assign dout = mem_q[sp_q - 1'b1];
  always_comb sp_d = clear ? '0 : (push && !full) ? sp_q + 1'b1 : (pop && !empty) ? sp_q - 1'b1 : sp_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sp_q <= '0;
    else sp_q <= sp_d;
  always_ff @(posedge clk)
    if (push && !full && !clear) mem_q[sp_q] <= din;
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: ROM-driven program sequencer with timed actuator steps, counters,
// call/return stack, abort vector and fault reporting.
module wash_sequencer
  import wash_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_NUM = 4,
  parameter int CHAN_NUM = 4,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] ABORT_VEC = 8'hF0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  tick,
  input  logic                  pause,
  input  logic                  abort,
  input  logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [CHAN_NUM-1:0]   ctrl,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            fault_code
);
  localparam int RW = REG_NUM > 1 ? $clog2(REG_NUM) : 1;
  localparam int CW = CHAN_NUM > 1 ? $clog2(CHAN_NUM) : 1;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, ret_pc;
  logic [ARG_W-1:0] regs_q [REG_NUM];
  logic [ARG_W-1:0] regs_d [REG_NUM];
  logic [ARG_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0] chan_q, chan_d;
  logic run_q, run_d;
  logic [2:0] fc_q, fc_d;
  logic push, pop, full, empty;
  logic [OP_W-1:0] op;
  logic [IDX_W-1:0] idx;
  logic [ARG_W-1:0] arg, rsel;
  logic [ADDR_WIDTH-1:0] target, pc_inc;
  logic [RW-1:0] ridx;
  logic reg_ok, chan_ok;
  assign op = instr[7:0];
  assign idx = instr[15:8];
  assign arg = instr[31:16];
  assign target = arg[ADDR_WIDTH-1:0];
  assign pc_inc = pc_q + 1'b1;
  assign ridx = idx[RW-1:0];
  assign rsel = regs_q[ridx];
  assign reg_ok = 32'(idx) < REG_NUM;
  assign chan_ok = 32'(idx) < CHAN_NUM;
  call_stack #(.ADDR_WIDTH(ADDR_WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clear(abort),
    .din(pc_inc), .dout(ret_pc), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    regs_d = regs_q;
    cnt_d = cnt_q;
    chan_d = chan_q;
    run_d = run_q;
    fc_d = fc_q;
    push = 1'b0;
    pop = 1'b0;
    if (abort) begin
      state_d = S_EXEC;
      pc_d = ABORT_VEC;
      cnt_d = '0;
      fc_d = FC_NONE;
    end else if (ena && state_q == S_TIMED) begin
      if (tick && !pause) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 16'd1) begin
          state_d = S_EXEC;
          pc_d = pc_inc;
        end
      end
    end else if (ena && state_q == S_EXEC) begin
      // Every faulting path leaves pc untouched so it points at the culprit.
      case (op)
        OP_HALT: state_d = S_HALT;
        OP_WAIT, OP_RUN:
          if (op == OP_RUN && !chan_ok) begin
            state_d = S_FAULT;
            fc_d = FC_IDX;
          end else if (arg == '0) pc_d = pc_inc;
          else begin
            state_d = S_TIMED;
            cnt_d = arg;
            chan_d = idx[CW-1:0];
            run_d = op == OP_RUN;
          end
        OP_SET, OP_DEC:
          if (!reg_ok) begin
            state_d = S_FAULT;
            fc_d = FC_IDX;
          end else begin
            regs_d[ridx] = op == OP_SET ? arg : rsel - 1'b1;
            pc_d = pc_inc;
          end
        OP_J: pc_d = target;
        OP_JZ, OP_JNZ:
          if (!reg_ok) begin
            state_d = S_FAULT;
            fc_d = FC_IDX;
          end else pc_d = ((rsel == '0) == (op == OP_JZ)) ? target : pc_inc;
        OP_CALL:
          if (full) begin
            state_d = S_FAULT;
            fc_d = FC_OVF;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        OP_RET:
          if (empty) begin
            state_d = S_FAULT;
            fc_d = FC_UNF;
          end else begin
            pop = 1'b1;
            pc_d = ret_pc;
          end
        default: begin
          state_d = S_FAULT;
          fc_d = FC_ILLEGAL;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_EXEC;
      pc_q <= '0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      cnt_q <= '0;
      chan_q <= '0;
      run_q <= 1'b0;
      fc_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      regs_q <= regs_d;
      cnt_q <= cnt_d;
      chan_q <= chan_d;
      run_q <= run_d;
      fc_q <= fc_d;
    end
  assign ctrl = (state_q == S_TIMED && run_q && ena && !pause && !abort) ? CHAN_NUM'(1) << chan_q : '0;
  assign pc = pc_q;
  assign busy = state_q == S_TIMED;
  assign halted = state_q == S_HALT;
  assign fault = state_q == S_FAULT;
  assign fault_code = fc_q;
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed programs with a scoreboard queue of expected outputs checked each falling edge.
module tb_wash_sequencer;
  import wash_seq_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, tick = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [31:0] instr;
  logic [7:0] pc;
  logic [3:0] ctrl;
  logic busy, halted, fault;
  logic [2:0] fault_code;
  logic [31:0] rom [256];
  typedef struct {
    string nm;
    logic [17:0] exp;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  logic [17:0] act;
  int checks = 0, errors = 0;
  wash_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .pause(pause), .abort(abort),
    .instr(instr), .pc(pc), .ctrl(ctrl), .busy(busy), .halted(halted), .fault(fault),
    .fault_code(fault_code)
  );
  assign instr = rom[pc];
  assign act = {pc, ctrl, busy, halted, fault, fault_code};
  always #5 clk = ~clk;
  always @(negedge clk)
    while (q.size() > 0) begin
      e_m = q.pop_front();
      checks++;
      if (act !== e_m.exp) begin
        errors++;
        $display("FAIL %s: got pc=%h ctrl=%b busy=%b halted=%b fault=%b code=%0d, expected pc=%h ctrl=%b busy=%b halted=%b fault=%b code=%0d",
                 e_m.nm, act[17:10], act[9:6], act[5], act[4], act[3], act[2:0],
                 e_m.exp[17:10], e_m.exp[9:6], e_m.exp[5], e_m.exp[4], e_m.exp[3], e_m.exp[2:0]);
      end
    end
  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] idx, input logic [15:0] arg);
    return {arg, idx, op};
  endfunction
  task automatic cyc(input logic t, input logic p, input logic e, input logic a, input string nm,
                     input logic [7:0] epc, input logic [3:0] ec, input logic eb, input logic eh,
                     input logic ef, input logic [2:0] efc);
    tick = t;
    pause = p;
    ena = e;
    abort = a;
    q.push_back('{nm, {epc, ec, eb, eh, ef, efc}});
    @(posedge clk);
    #1;
  endtask
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(OP_HALT, 8'd0, 16'd0);
  endtask
  task automatic start();
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h ctrl=%b busy=%b halted=%b fault=%b code=%0d",
               act[17:10], act[9:6], act[5], act[4], act[3], act[2:0]);
    end
    cyc(0, 0, 1, 0, "reset", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    rst_n = 1'b1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    clear_rom();
    rom[0] = enc(OP_RUN, 8'd2, 16'd3);
    start();
    cyc(1, 0, 1, 0, "run_issue", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) cyc(0, 0, 1, 0, "run_drive", 8'h00, 4'b0100, 1, 0, 0, 3'd0);
      cyc(1, 0, 1, 0, "run_tick", 8'h00, 4'b0100, 1, 0, 0, 3'd0);
    end
    cyc(0, 0, 1, 0, "run_done", 8'h01, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "run_halt", 8'h01, 4'b0000, 0, 1, 0, 3'd0);
    clear_rom();
    rom[0] = enc(OP_SET, 8'd1, 16'd2);
    rom[1] = enc(OP_DEC, 8'd1, 16'd0);
    rom[2] = enc(OP_JNZ, 8'd1, 16'd1);
    rom[3] = enc(OP_JZ, 8'd1, 16'd6);
    start();
    cyc(0, 0, 1, 0, "loop_set", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "loop_dec1", 8'h01, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "loop_jnz_taken", 8'h02, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "loop_dec2", 8'h01, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "loop_jnz_exit", 8'h02, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "loop_jz_r1", 8'h03, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "loop_at_6", 8'h06, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "loop_halt", 8'h06, 4'b0000, 0, 1, 0, 3'd0);
    clear_rom();
    rom[0] = enc(OP_RUN, 8'd0, 16'd5);
    start();
    cyc(0, 0, 1, 0, "p_issue", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "p_tick1", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "p_gap", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "p_tick2", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(1, 1, 1, 0, "p_lost1", 8'h00, 4'b0000, 1, 0, 0, 3'd0);
    cyc(0, 1, 1, 0, "p_paused", 8'h00, 4'b0000, 1, 0, 0, 3'd0);
    cyc(1, 1, 1, 0, "p_lost2", 8'h00, 4'b0000, 1, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "p_resume", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "p_tick3", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "p_tick4", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "p_before_last", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "p_tick5", 8'h00, 4'b0001, 1, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "p_done", 8'h01, 4'b0000, 0, 0, 0, 3'd0);
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = enc(OP_CALL, 8'd0, 16'(i + 1));
    rom[8'hF0] = enc(OP_RET, 8'd0, 16'd0);
    start();
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, "call_nest", 8'(i), 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "call_ovf", 8'h04, 4'b0000, 0, 0, 1, 3'd3);
    cyc(0, 0, 0, 1, "abort_ena_low", 8'h04, 4'b0000, 0, 0, 1, 3'd3);
    cyc(0, 0, 1, 0, "abort_vec", 8'hF0, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "ret_empty", 8'hF0, 4'b0000, 0, 0, 1, 3'd4);
    clear_rom();
    rom[0] = enc(OP_CALL, 8'd0, 16'd3);
    rom[3] = enc(OP_RET, 8'd0, 16'd0);
    start();
    cyc(0, 0, 1, 0, "cr_call", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "cr_ret", 8'h03, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "cr_back", 8'h01, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "cr_halt", 8'h01, 4'b0000, 0, 1, 0, 3'd0);
    clear_rom();
    rom[0] = enc(8'h7F, 8'd0, 16'd0);
    start();
    cyc(0, 0, 1, 0, "ill_exec", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "ill_fault", 8'h00, 4'b0000, 0, 0, 1, 3'd1);
    rom[0] = enc(OP_RUN, 8'd4, 16'd3);
    start();
    cyc(0, 0, 1, 0, "chan_exec", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "chan_fault", 8'h00, 4'b0000, 0, 0, 1, 3'd2);
    rom[0] = enc(OP_SET, 8'd4, 16'd1);
    start();
    cyc(0, 0, 1, 0, "reg_exec", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "reg_fault", 8'h00, 4'b0000, 0, 0, 1, 3'd2);
    clear_rom();
    rom[0] = enc(OP_RUN, 8'd1, 16'd4);
    start();
    cyc(0, 0, 1, 0, "rst_issue", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "rst_drive", 8'h00, 4'b0010, 1, 0, 0, 3'd0);
    rst_n = 1'b0;
    cyc(0, 0, 1, 0, "rst_mid_run", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, "rst_restart", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    rom[0] = enc(OP_RUN, 8'd1, 16'd2);
    start();
    cyc(0, 0, 1, 0, "ena_issue", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "ena_tick1", 8'h00, 4'b0010, 1, 0, 0, 3'd0);
    cyc(1, 0, 0, 0, "ena_low_tick", 8'h00, 4'b0000, 1, 0, 0, 3'd0);
    cyc(0, 0, 0, 0, "ena_low_hold", 8'h00, 4'b0000, 1, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "ena_resume", 8'h00, 4'b0010, 1, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "ena_tick2", 8'h00, 4'b0010, 1, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "ena_done", 8'h01, 4'b0000, 0, 0, 0, 3'd0);
    clear_rom();
    rom[0] = enc(OP_WAIT, 8'd0, 16'd2);
    start();
    cyc(0, 0, 1, 0, "w_issue", 8'h00, 4'b0000, 0, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "w_tick1", 8'h00, 4'b0000, 1, 0, 0, 3'd0);
    cyc(1, 0, 1, 0, "w_tick2", 8'h00, 4'b0000, 1, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "w_expired", 8'h01, 4'b0000, 0, 0, 0, 3'd0);
    cyc(0, 0, 1, 0, "w_halt", 8'h01, 4'b0000, 0, 1, 0, 3'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised second-generation program sequencer for the washing controller. It executes 32-bit instructions from an external program ROM addressed by `pc`. It generalises the fixed four-actuator, two-register core to N actuator channels and N counters. It adds tick-based timed steps, pause, a call/return stack, an abort vector and fault reporting. It sits between the program ROM and the actuator drivers (valves, pump, motor).

## Interface
Parameters:
- `ADDR_WIDTH`, 8: program address width (≤16).
- `REG_NUM`, 4: number of 16-bit counters.
- `CHAN_NUM`, 4: number of actuator channels.
- `STACK_DEPTH`, 4: return-stack entries.
- `ABORT_VEC`, 8'hF0: abort handler address.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: run enable; low freezes all state.
- `tick` in 1: time-base strobe, one cycle wide.
- `pause` in 1: suspends timed steps (door open).
- `abort` in 1: jump to `ABORT_VEC` and clear the stack.
- `instr` in 32: ROM word at `pc`, valid in the same cycle.
- `pc` out ADDR_WIDTH: program counter.
- `ctrl` out CHAN_NUM: one-hot actuator drive.
- `busy` out 1: state is TIMED.
- `halted` out 1: state is HALT.
- `fault` out 1: state is FAULT.
- `fault_code` out 3: cause of the last fault.

## Operation
Instruction fields: opcode = `instr[7:0]`, idx = `instr[15:8]`, arg = `instr[31:16]`.

Opcodes:
- 00 HALT.
- 10 WAIT arg.
- 11 RUN idx,arg.
- 21 SET idx,arg.
- 22 DEC idx.
- 30 J arg.
- 31 JZ idx,arg.
- 32 JNZ idx,arg.
- 33 CALL arg.
- 34 RET.

States: EXEC, TIMED, HALT, FAULT.

EXEC executes one instruction per cycle:
- SET: reg[idx] = arg.
- DEC: reg[idx] − 1, wrapping from 0 to FFFF.
- SET, DEC and a not-taken JZ/JNZ each advance pc+1.
- J, and a taken JZ/JNZ: pc = arg[ADDR_WIDTH-1:0].
- CALL: push pc+1, then jump to arg.
- RET: pop into pc.
- HALT: go to HALT; pc holds.
- WAIT/RUN with arg=0: pc+1, no drive.
- WAIT/RUN with arg≠0: latch idx and arg into the channel and count registers, go to TIMED; pc holds.

TIMED:
- `ctrl` = onehot(chan) for RUN, 0 for WAIT. Forced to 0 while `pause`.
- On `tick & ~pause`, count decrements.
- A tick with count==1 returns to EXEC with pc+1.
- Drive length is exactly arg ticks.

FAULT is entered from EXEC, with pc holding at the faulting instruction. `fault_code` values:
- 1: illegal opcode.
- 2: idx ≥ REG_NUM (SET/DEC/JZ/JNZ), or idx ≥ CHAN_NUM (RUN).
- 3: CALL with a full stack.
- 4: RET with an empty stack.

`abort` has highest priority, is honoured even when `ena` low, and exits HALT/FAULT. It sets:
- pc = ABORT_VEC
- state = EXEC
- sp = 0
- count = 0
- fault_code = 0

Counters are not cleared by abort.

`ena` low (without `abort`):
- state, pc, registers, count and stack all hold.
- `ctrl` is forced to 0.
- `tick` is ignored.

Reset values:
- pc = 0, state = EXEC.
- All registers 0, count 0, sp 0.
- `ctrl` 0, `busy`/`halted`/`fault` 0, `fault_code` 0.

## Timing
- All state updates on the rising `clk` edge. Reset is asynchronous: assertion clears state immediately, including mid-TIMED.
- `ctrl` is combinational from state, chan, `pause`, `ena` and `abort`. It is 0 in the same cycle `abort` is asserted.
- RUN arg=N driving:
  - `ctrl` rises the cycle after RUN is sampled in EXEC.
  - It falls on the cycle after the N-th unpaused tick; pc+1 in that cycle.
- A tick in the same cycle RUN enters TIMED is not counted.
- Pause while TIMED: the count freezes; a tick coincident with `pause` is lost.
- JZ/JNZ test the register value before any update in the same cycle; only one instruction executes per cycle.
- Stack is full at sp==STACK_DEPTH and empty at sp==0.
- pc+1 wraps from 2^ADDR_WIDTH−1 to 0.

## Structure
- Package `wash_seq_pkg` holds:
  - opcode constants
  - state enum
  - fault-code constants
  - field-slice widths
- Sub-module `call_stack` (parameters ADDR_WIDTH, STACK_DEPTH):
  - inputs: push, pop, clear, din
  - outputs: dout, full, empty
  - async reset
- Registers and the timed counter stay in the top level.

## Test plan
- RUN ch2,3 with tick every 4 cycles → `ctrl`=4'b0100 for exactly 3 ticks, then pc+1, `busy` 1→0.
- SET r1,2; loop DEC r1 / JNZ r1,loop → loop body runs 2 times; exit with r1=0, pc past JNZ.
- RUN ch0,5 with `pause` held across 2 ticks → `ctrl`=0 while paused; total 5 unpaused ticks before advance.
- CALL nested 5 deep with STACK_DEPTH=4 → `fault`=1, `fault_code`=3, pc at the 5th CALL; then `abort` → pc=F0, `fault`=0, sp=0.
- Opcode 8'h7F → FAULT code 1; RUN idx=CHAN_NUM → FAULT code 2; RET at sp=0 → FAULT code 4.
- Reset asserted mid-RUN → `ctrl`=0 immediately, pc=0; `ena` low mid-RUN → `ctrl`=0, count holds, resumes on `ena` high.
